// File: rtl/force_pkg.sv
// Shared types and default sizes for the force/release override bank.
package force_pkg;

   // Default geometry of the bank.
   localparam int unsigned DEF_WIDTH     = 32;
   localparam int unsigned DEF_NCH       = 4;
   localparam logic [31:0] DEF_RESET_VAL = 32'h666;

   // Channel semantics: variable retains a released value, net falls back to its driver.
   typedef enum logic {
      FM_VAR = 1'b0,
      FM_NET = 1'b1
   } force_mode_e;

   // Architectural state of one channel at the default width.
   typedef struct packed {
      logic [DEF_WIDTH-1:0] pval;
      logic [DEF_WIDTH-1:0] fmask;
      logic [DEF_WIDTH-1:0] fval;
   } chan_state_t;

endpackage

// File: rtl/force_chan.sv
// One channel of the override bank: procedural value plus per-bit force mask/value.
// Per-bit priority within an edge is release, then force, then write.
module force_chan
   import force_pkg::*;
#(
   parameter int unsigned       WIDTH     = DEF_WIDTH,
   parameter logic [WIDTH-1:0]  RESET_VAL = WIDTH'(DEF_RESET_VAL),
   parameter force_mode_e       MODE      = FM_VAR
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             force_en,
   input  logic [WIDTH-1:0] force_mask,
   input  logic [WIDTH-1:0] force_data,
   input  logic             release_en,
   input  logic [WIDTH-1:0] release_mask,
   output logic [WIDTH-1:0] val,
   output logic             forced,
   output logic             wr_blocked
);

   logic [WIDTH-1:0] pval_q,  pval_d;
   logic [WIDTH-1:0] fmask_q, fmask_d;
   logic [WIDTH-1:0] fval_q,  fval_d;
   logic             wr_blocked_q, wr_blocked_d;

   logic [WIDTH-1:0] rel_bits;
   logic [WIDTH-1:0] frc_bits;
   logic [WIDTH-1:0] fmask_mid;
   logic [WIDTH-1:0] pval_mid;

   // Next-state: apply release, then force, then the procedural write.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      rel_bits     = '0;
      frc_bits     = '0;
      fmask_mid    = fmask_q;
      pval_mid     = pval_q;
      fmask_d      = fmask_q;
      fval_d       = fval_q;
      pval_d       = pval_q;
      wr_blocked_d = 1'b0;

      if (release_en) rel_bits = release_mask;
      if (force_en)   frc_bits = force_mask;

      // Release. In variable mode only bits that are actually forced hand their
      // forced value over to pval; releasing an unforced bit changes nothing.
      fmask_mid = fmask_q & ~rel_bits;
      if (MODE == FM_VAR) begin
         pval_mid = (pval_q & ~(rel_bits & fmask_q)) | (fval_q & rel_bits & fmask_q);
      end

      // Force: wins over a release of the same bit in the same cycle.
      fmask_d = fmask_mid | frc_bits;
      fval_d  = (fval_q & ~frc_bits) | (force_data & frc_bits);

      // Write: net mode always updates the driver; variable mode skips forced bits.
      pval_d = pval_mid;
      if (wr_en) begin
         if (MODE == FM_NET) begin
            pval_d = wr_data;
         end else begin
            pval_d       = (pval_mid & fmask_d) | (wr_data & ~fmask_d);
            wr_blocked_d = &fmask_d;
         end
      end
   end

   // State register with synchronous active-high reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (rst) begin
         pval_q       <= RESET_VAL;
         fmask_q      <= '0;
         fval_q       <= '0;
         wr_blocked_q <= 1'b0;
      end else begin
         pval_q       <= pval_d;
         fmask_q      <= fmask_d;
         fval_q       <= fval_d;
         wr_blocked_q <= wr_blocked_d;
      end
   end

   assign val        = (fmask_q & fval_q) | (~fmask_q & pval_q);
   assign forced     = |fmask_q;
   assign wr_blocked = wr_blocked_q;

endmodule

// File: rtl/force_override_bank.sv
// Multi-channel force/release override bank: NCH independent force_chan instances.
module force_override_bank
   import force_pkg::*;
#(
   parameter int unsigned       WIDTH     = DEF_WIDTH,
   parameter int unsigned       NCH       = DEF_NCH,
   parameter logic [WIDTH-1:0]  RESET_VAL = WIDTH'(DEF_RESET_VAL),
   parameter logic [NCH-1:0]    NET_MODE  = '0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NCH-1:0]       wr_en,
   input  logic [NCH*WIDTH-1:0] wr_data,
   input  logic [NCH-1:0]       force_en,
   input  logic [NCH*WIDTH-1:0] force_mask,
   input  logic [NCH*WIDTH-1:0] force_data,
   input  logic [NCH-1:0]       release_en,
   input  logic [NCH*WIDTH-1:0] release_mask,
   output logic [NCH*WIDTH-1:0] val,
   output logic [NCH-1:0]       forced,
   output logic [NCH-1:0]       wr_blocked
);

   for (genvar c = 0; c < NCH; c++) begin : g_chan
      force_chan #(
         .WIDTH     (WIDTH),
         .RESET_VAL (RESET_VAL),
         .MODE      (NET_MODE[c] ? FM_NET : FM_VAR)
      ) u_chan (
         .clk          (clk),
         .rst          (rst),
         .wr_en        (wr_en[c]),
         .wr_data      (wr_data[c*WIDTH +: WIDTH]),
         .force_en     (force_en[c]),
         .force_mask   (force_mask[c*WIDTH +: WIDTH]),
         .force_data   (force_data[c*WIDTH +: WIDTH]),
         .release_en   (release_en[c]),
         .release_mask (release_mask[c*WIDTH +: WIDTH]),
         .val          (val[c*WIDTH +: WIDTH]),
         .forced       (forced[c]),
         .wr_blocked   (wr_blocked[c])
      );
   end

endmodule

// File: tb/tb_force_override_bank.sv
// Self-checking bench for force_override_bank: directed scenarios plus random
// strobes compared every cycle against a per-bit behavioural model.
module tb_force_override_bank;
   import force_pkg::*;

   localparam int          W    = 32;
   localparam int          N    = 4;
   localparam logic [W-1:0] RV  = 32'h666;
   localparam logic [N-1:0] NETM = 4'b1010;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   wr_en, force_en, release_en;
   logic [N*W-1:0] wr_data, force_mask, force_data, release_mask;
   logic [N*W-1:0] val;
   logic [N-1:0]   forced, wr_blocked;

   always #5 clk = ~clk;

   force_override_bank #(
      .WIDTH(W), .NCH(N), .RESET_VAL(RV), .NET_MODE(NETM)
   ) dut (
      .clk(clk), .rst(rst),
      .wr_en(wr_en), .wr_data(wr_data),
      .force_en(force_en), .force_mask(force_mask), .force_data(force_data),
      .release_en(release_en), .release_mask(release_mask),
      .val(val), .forced(forced), .wr_blocked(wr_blocked)
   );

   // Reference model state.
   chan_state_t m     [N];
   logic        m_blk [N];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] model_val(input int c);
      logic [W-1:0] v;
      for (int b = 0; b < W; b++) v[b] = m[c].fmask[b] ? m[c].fval[b] : m[c].pval[b];
      return v;
   endfunction

   // Bit-serial application of the release -> force -> write rules.
   task automatic model_edge();
      for (int c = 0; c < N; c++) begin
         if (rst) begin
            m[c].pval  = RV;
            m[c].fmask = '0;
            m[c].fval  = '0;
            m_blk[c]   = 1'b0;
         end else begin
            for (int b = 0; b < W; b++) begin
               if (release_en[c] && release_mask[c*W+b]) begin
                  if (!NETM[c] && m[c].fmask[b]) m[c].pval[b] = m[c].fval[b];
                  m[c].fmask[b] = 1'b0;
               end
               if (force_en[c] && force_mask[c*W+b]) begin
                  m[c].fmask[b] = 1'b1;
                  m[c].fval[b]  = force_data[c*W+b];
               end
               if (wr_en[c] && (NETM[c] || !m[c].fmask[b])) m[c].pval[b] = wr_data[c*W+b];
            end
            m_blk[c] = wr_en[c] && !NETM[c] && (m[c].fmask == '1);
         end
      end
   endtask

   task automatic compare_model();
      for (int c = 0; c < N; c++) begin
         check($sformatf("model_val%0d", c), val[c*W +: W], model_val(c));
         check($sformatf("model_forced%0d", c), W'(forced[c]), W'(|m[c].fmask));
         check($sformatf("model_blk%0d", c), W'(wr_blocked[c]), W'(m_blk[c]));
      end
   endtask

   // One clock: model follows the same edge, outputs sampled 1 time unit later.
   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      compare_model();
   endtask

   // Directed check against fixed expected constants.
   task automatic expect_ch(input string tag, input int c, input logic [W-1:0] v,
                            input logic f, input logic blk);
      check({tag, "_val"},    val[c*W +: W],      v);
      check({tag, "_forced"}, W'(forced[c]),     W'(f));
      check({tag, "_blk"},    W'(wr_blocked[c]), W'(blk));
   endtask

   // Strobes low; data and masks randomised to show they are ignored.
   task automatic idle();
      rst        = 1'b0;
      wr_en      = '0;
      force_en   = '0;
      release_en = '0;
      for (int c = 0; c < N; c++) begin
         wr_data[c*W +: W]      = $urandom;
         force_mask[c*W +: W]   = $urandom;
         force_data[c*W +: W]   = $urandom;
         release_mask[c*W +: W] = $urandom;
      end
   endtask

   task automatic do_wr(input int c, input logic [W-1:0] d);
      wr_en[c] = 1'b1;
      wr_data[c*W +: W] = d;
   endtask

   task automatic do_force(input int c, input logic [W-1:0] mk, input logic [W-1:0] d);
      force_en[c] = 1'b1;
      force_mask[c*W +: W] = mk;
      force_data[c*W +: W] = d;
   endtask

   task automatic do_rel(input int c, input logic [W-1:0] mk);
      release_en[c] = 1'b1;
      release_mask[c*W +: W] = mk;
   endtask

   initial begin
      idle();
      rst = 1'b1;
      step();
      step();
      idle();
      step();
      for (int c = 0; c < N; c++) expect_ch($sformatf("reset%0d", c), c, RV, 1'b0, 1'b0);

      // 1: variable-mode sequence on ch0.
      idle(); do_force(0, 32'hFFFF_FFFF, 32'h0000_FFFF); step();
      expect_ch("t1_force", 0, 32'hFFFF, 1'b1, 1'b0);
      idle(); do_wr(0, 32'h543); step();
      expect_ch("t1_wr_blocked", 0, 32'hFFFF, 1'b1, 1'b1);
      idle(); step();
      expect_ch("t1_blk_pulse_end", 0, 32'hFFFF, 1'b1, 1'b0);
      idle(); do_rel(0, 32'hFFFF_FFFF); step();
      expect_ch("t1_release", 0, 32'hFFFF, 1'b0, 1'b0);
      idle(); do_wr(0, 32'h544); step();
      expect_ch("t1_wr", 0, 32'h544, 1'b0, 1'b0);

      // 2: net mode on ch1.
      idle(); do_wr(1, 32'h100); do_force(1, 32'hFFFF_FFFF, 32'hABCD); step();
      expect_ch("t2_force", 1, 32'hABCD, 1'b1, 1'b0);
      idle(); do_wr(1, 32'h200); step();
      expect_ch("t2_wr_forced", 1, 32'hABCD, 1'b1, 1'b0);
      idle(); do_rel(1, 32'hFFFF_FFFF); step();
      expect_ch("t2_release", 1, 32'h200, 1'b0, 1'b0);

      // 3: partial force, variable mode on ch2.
      idle(); do_force(2, 32'h0000_00FF, 32'h55); step();
      expect_ch("t3_force", 2, 32'h655, 1'b1, 1'b0);
      idle(); do_wr(2, 32'h1234_5678); step();
      expect_ch("t3_wr", 2, 32'h1234_5655, 1'b1, 1'b0);
      idle(); do_rel(2, 32'h0000_000F); step();
      expect_ch("t3_release", 2, 32'h1234_5655, 1'b1, 1'b0);
      idle(); do_rel(2, 32'h0000_00F0); step();
      expect_ch("t3_release_rest", 2, 32'h1234_5655, 1'b0, 1'b0);

      // 4: simultaneous events on ch2.
      idle(); do_force(2, 32'h0000_0F00, 32'h0000_0A00); do_rel(2, 32'h0000_0F00); step();
      expect_ch("t4_force_rel", 2, 32'h1234_5A55, 1'b1, 1'b0);
      idle(); do_wr(2, 32'h777); do_rel(2, 32'hFFFF_FFFF); step();
      expect_ch("t4_wr_rel", 2, 32'h777, 1'b0, 1'b0);

      // Zero masks with strobes asserted are no-ops on ch0.
      idle(); do_force(0, '0, 32'hDEAD_BEEF); do_rel(0, '0); step();
      expect_ch("zero_mask", 0, 32'h544, 1'b0, 1'b0);

      // 5: reset while every channel is forced and strobes are active.
      idle();
      for (int c = 0; c < N; c++) do_force(c, 32'hFFFF_FFFF, $urandom);
      step();
      idle();
      rst = 1'b1;
      wr_en = '1; force_en = '1; release_en = '1;
      step();
      for (int c = 0; c < N; c++) expect_ch($sformatf("t5_rst%0d", c), c, RV, 1'b0, 1'b0);

      // 6: random strobes on all channels, checked every cycle by the model.
      for (int i = 0; i < 600; i++) begin
         idle();
         rst = ($urandom_range(0, 79) == 0);
         for (int c = 0; c < N; c++) begin
            wr_en[c]      = $urandom_range(0, 2) == 0;
            force_en[c]   = $urandom_range(0, 2) == 0;
            release_en[c] = $urandom_range(0, 3) == 0;
            case ($urandom_range(0, 3))
               0: force_mask[c*W +: W] = '1;
               1: force_mask[c*W +: W] = $urandom & $urandom;
               2: force_mask[c*W +: W] = '0;
               default: force_mask[c*W +: W] = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) release_mask[c*W +: W] = '1;
         end
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
